// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction-timer display path.
// Scheduler states, BCD digit type, display limits.
package rt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CONV
  } sched_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int MAX_DISP_VAL = 9999;
  localparam int MS_BIN_W     = 14;

endpackage

// File: rtl/bcd_conv_sched_if.sv
// Handshake bundle between the scheduler and the bin2bcd converter.
// master: scheduler (drives start/operand); slave: converter.
interface bcd_conv_sched_if #(
  parameter int BIN_W = rt_pkg::MS_BIN_W
) ();
  import rt_pkg::*;

  logic             conv_start;
  logic [BIN_W-1:0] conv_bin;
  logic             conv_ready;
  logic             conv_done_tick;
  bcd_digit_t       conv_bcd3;
  bcd_digit_t       conv_bcd2;
  bcd_digit_t       conv_bcd1;
  bcd_digit_t       conv_bcd0;

  modport master (
    output conv_start,
    output conv_bin,
    input  conv_ready,
    input  conv_done_tick,
    input  conv_bcd3,
    input  conv_bcd2,
    input  conv_bcd1,
    input  conv_bcd0
  );

  modport slave (
    input  conv_start,
    input  conv_bin,
    output conv_ready,
    output conv_done_tick,
    output conv_bcd3,
    output conv_bcd2,
    output conv_bcd1,
    output conv_bcd0
  );

endinterface

// File: rtl/lz_blank.sv
// Leading-zero blanker for a 4-digit BCD display.
// Ports: d3..d1 digits in (d0 never blanks), blank[3:0] out.
module lz_blank
  import rt_pkg::*;
(
  input  bcd_digit_t d3,
  input  bcd_digit_t d2,
  input  bcd_digit_t d1,
  output logic [3:0] blank
);

  always_comb begin
    blank    = 4'b0000;
    blank[3] = (d3 == 4'd0);
    blank[2] = blank[3] & (d2 == 4'd0);
    blank[1] = blank[2] & (d1 == 4'd0);
    blank[0] = 1'b0;
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Sequences the shared bin2bcd converter: rate-limited conversions on
// value change or forced refresh, holds blanked digits, flags timeouts.
// Ports: clk, rst (sync, active-high), bin_in, force_req, cv (master),
// bcd3..bcd0, blank, ovf, busy, err.
module bcd_conv_sched
  import rt_pkg::*;
#(
  parameter int BIN_W         = MS_BIN_W,
  parameter int MAX_VAL       = MAX_DISP_VAL,
  parameter int UPDATE_CYCLES = 100000,
  parameter int CONV_TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  // "force" is a reserved word, hence the _req suffix
  input  logic             force_req,
  bcd_conv_sched_if.master cv,
  output bcd_digit_t       bcd3,
  output bcd_digit_t       bcd2,
  output bcd_digit_t       bcd1,
  output bcd_digit_t       bcd0,
  output logic [3:0]       blank,
  output logic             ovf,
  output logic             busy,
  output logic             err
);

  localparam int RATE_W = $clog2(UPDATE_CYCLES + 1);
  localparam int TMO_W  = $clog2(CONV_TIMEOUT + 1);

  localparam logic [RATE_W-1:0] RATE_MAX =
    RATE_W'(UPDATE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX =
    TMO_W'(CONV_TIMEOUT - 1);
  localparam logic [BIN_W-1:0] SAT_VAL =
    BIN_W'(MAX_VAL);

  sched_state_t      state_q, state_d;
  logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              force_pend_q, force_pend_d;
  logic [BIN_W-1:0]  conv_bin_q, conv_bin_d;
  logic [BIN_W-1:0]  last_bin_q, last_bin_d;
  logic              pend_ovf_q, pend_ovf_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  bcd_digit_t        d3_q, d3_d;
  bcd_digit_t        d2_q, d2_d;
  bcd_digit_t        d1_q, d1_d;
  bcd_digit_t        d0_q, d0_d;

  logic             sat_flag;
  logic [BIN_W-1:0] sat_val;

  always_comb begin
    sat_flag = (bin_in > SAT_VAL);
    sat_val  = sat_flag ? SAT_VAL : bin_in;
  end

  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    force_pend_d = force_pend_q;
    conv_bin_d   = conv_bin_q;
    last_bin_d   = last_bin_q;
    pend_ovf_d   = pend_ovf_q;
    ovf_d        = ovf_q;
    err_d        = err_q;
    d3_d         = d3_q;
    d2_d         = d2_q;
    d1_d         = d1_q;
    d0_d         = d0_q;
    rate_cnt_d   = (rate_cnt_q == RATE_MAX) ?
                   rate_cnt_q : rate_cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (cv.conv_ready &&
            (force_pend_q ||
             (sat_val != last_bin_q &&
              rate_cnt_q == RATE_MAX))) begin
          state_d      = ISSUE;
          conv_bin_d   = sat_val;
          pend_ovf_d   = sat_flag;
          force_pend_d = 1'b0;
        end
      end
      ISSUE: begin
        state_d    = CONV;
        tmo_cnt_d  = '0;
        rate_cnt_d = '0;
      end
      CONV: begin
        // a tick on the timeout cycle still wins
        if (cv.conv_done_tick) begin
          state_d    = IDLE;
          d3_d       = cv.conv_bcd3;
          d2_d       = cv.conv_bcd2;
          d1_d       = cv.conv_bcd1;
          d0_d       = cv.conv_bcd0;
          ovf_d      = pend_ovf_q;
          last_bin_d = conv_bin_q;
        end else if (tmo_cnt_q == TMO_MAX) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // a force landing on ISSUE entry re-arms
    force_pend_d = force_pend_d | force_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rate_cnt_q   <= RATE_MAX;
      tmo_cnt_q    <= '0;
      force_pend_q <= 1'b0;
      conv_bin_q   <= '0;
      last_bin_q   <= '0;
      pend_ovf_q   <= 1'b0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      d3_q         <= '0;
      d2_q         <= '0;
      d1_q         <= '0;
      d0_q         <= '0;
    end else begin
      state_q      <= state_d;
      rate_cnt_q   <= rate_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      force_pend_q <= force_pend_d;
      conv_bin_q   <= conv_bin_d;
      last_bin_q   <= last_bin_d;
      pend_ovf_q   <= pend_ovf_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      d3_q         <= d3_d;
      d2_q         <= d2_d;
      d1_q         <= d1_d;
      d0_q         <= d0_d;
    end
  end

  lz_blank u_lz_blank (
    .d3    (d3_q),
    .d2    (d2_q),
    .d1    (d1_q),
    .blank (blank)
  );

  assign cv.conv_start = (state_q == ISSUE);
  assign cv.conv_bin   = conv_bin_q;
  assign busy          = (state_q != IDLE);
  assign bcd3          = d3_q;
  assign bcd2          = d2_q;
  assign bcd1          = d1_q;
  assign bcd0          = d0_q;
  assign ovf           = ovf_q;
  assign err           = err_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Bench for bcd_conv_sched: converter model, value-level reference
// model compared every cycle, plus directed literal expectations.
module tb_bcd_conv_sched;
  import rt_pkg::*;

  localparam int W    = 14;
  localparam int UC   = 8;
  localparam int TO   = 16;
  localparam int MAXV = 9999;
  localparam int LAT  = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] bin_in = '0;
  logic         force_req = 1'b0;
  bcd_digit_t   bcd3, bcd2, bcd1, bcd0;
  logic [3:0]   blank;
  logic         ovf, busy, err;

  bcd_conv_sched_if #(.BIN_W(W)) ifc ();

  bcd_conv_sched #(
    .BIN_W         (W),
    .MAX_VAL       (MAXV),
    .UPDATE_CYCLES (UC),
    .CONV_TIMEOUT  (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bin_in    (bin_in),
    .force_req (force_req),
    .cv        (ifc.master),
    .bcd3      (bcd3),
    .bcd2      (bcd2),
    .bcd1      (bcd1),
    .bcd0      (bcd0),
    .blank     (blank),
    .ovf       (ovf),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10),
            4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] blank_of(int v);
    return {v < 1000, v < 100, v < 10, 1'b0};
  endfunction

  // converter model
  logic         cv_idle = 1'b1;
  int           cv_cnt = 0;
  logic [W-1:0] cv_op = '0;
  logic         cv_tick = 1'b0;
  logic [15:0]  cv_dig = '0;
  logic         no_tick = 1'b0;
  logic         hold_ready = 1'b0;
  logic         start_seen = 1'b0;
  logic [W-1:0] op_seen = '0;

  assign ifc.conv_ready     = cv_idle && !hold_ready;
  assign ifc.conv_done_tick = cv_tick;
  assign ifc.conv_bcd3      = cv_dig[15:12];
  assign ifc.conv_bcd2      = cv_dig[11:8];
  assign ifc.conv_bcd1      = cv_dig[7:4];
  assign ifc.conv_bcd0      = cv_dig[3:0];

  always @(negedge clk) begin
    start_seen = ifc.conv_start;
    op_seen    = ifc.conv_bin;
  end

  always @(posedge clk) begin
    #1;
    cv_tick = 1'b0;
    if (!cv_idle) begin
      cv_cnt--;
      if (cv_cnt == 0) begin
        cv_idle = 1'b1;
        if (!no_tick) begin
          cv_tick = 1'b1;
          cv_dig  = to_bcd(int'(cv_op));
        end
      end
    end else if (start_seen) begin
      cv_idle = 1'b0;
      cv_cnt  = LAT;
      cv_op   = op_seen;
    end
  end

  // start monitor
  int           cyc = 0;
  int           n_start = 0;
  int           last_start_cyc = 0;
  int           prev_start_cyc = 0;
  int           last_start_bin = 0;

  always @(negedge clk) begin
    cyc++;
    if (ifc.conv_start === 1'b1) begin
      n_start++;
      prev_start_cyc = last_start_cyc;
      last_start_cyc = cyc;
      last_start_bin = int'(ifc.conv_bin);
    end
  end

  // reference model: phase 0 idle, 1 start pulse, 2 waiting
  logic m_ok = 1'b0;
  int   m_st, m_since, m_tmo, m_op, m_last, m_dval;
  logic m_fp, m_pov, m_ovf, m_err;

  always @(negedge clk) begin
    logic [37:0] e_v, a_v;
    int          sat, old;
    logic        nfp;
    if (m_ok) begin
      e_v = {m_st == 1, W'(m_op), m_st != 0,
             to_bcd(m_dval), blank_of(m_dval), m_ovf, m_err};
      a_v = {ifc.conv_start, ifc.conv_bin, busy,
             bcd3, bcd2, bcd1, bcd0, blank, ovf, err};
      chk("cycle", 64'(a_v), 64'(e_v));
    end
    if (rst) begin
      m_ok = 1'b1; m_st = 0; m_since = UC; m_tmo = 0;
      m_op = 0; m_last = 0; m_dval = 0;
      m_fp = 0; m_pov = 0; m_ovf = 0; m_err = 0;
    end else if (m_ok) begin
      sat = (int'(bin_in) > MAXV) ? MAXV : int'(bin_in);
      nfp = m_fp;
      old = m_st;
      case (old)
        0: if (ifc.conv_ready &&
               (m_fp || (sat != m_last && m_since >= UC))) begin
          m_st = 1; m_op = sat;
          m_pov = int'(bin_in) > MAXV; nfp = 0;
        end
        1: begin m_st = 2; m_tmo = 0; end
        default:
          if (ifc.conv_done_tick) begin
            m_dval = m_op; m_ovf = m_pov;
            m_last = m_op; m_st = 0;
          end else if (m_tmo == TO - 1) begin
            m_err = 1; m_st = 0;
          end else m_tmo++;
      endcase
      if (old == 1) m_since = 1;
      else if (m_since < UC) m_since++;
      m_fp = nfp | force_req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bound_fail(string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s act=expired exp=event", nm);
  endtask

  task automatic wait_done(int s0, int budget, string nm);
    int i = 0;
    while (!(n_start > s0 && !busy && !ifc.conv_start)
           && i < budget) begin
      step();
      i++;
    end
    if (i >= budget) bound_fail(nm);
  endtask

  task automatic wait_start(int s0, int budget, string nm);
    int i = 0;
    while (n_start <= s0 && i < budget) begin
      step();
      i++;
    end
    if (i >= budget) bound_fail(nm);
  endtask

  task automatic chk_disp(string nm, logic [15:0] d,
                          logic [3:0] b);
    chk({nm, "_bcd"}, {bcd3, bcd2, bcd1, bcd0}, d);
    chk({nm, "_blank"}, blank, b);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, i;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk_disp("rst", 16'h0000, 4'b1110);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_bin", ifc.conv_bin, 0);

    repeat (1000) step();
    chk("idle_no_start", n_start, 0);
    chk_disp("idle", 16'h0000, 4'b1110);

    s0 = n_start;
    bin_in = 14'd1234;
    step();
    chk("start_1cyc", ifc.conv_start, 1);
    chk("bin_1234", ifc.conv_bin, 1234);
    wait_done(s0, 50, "done_1234");
    chk_disp("v1234", 16'h1234, 4'b0000);
    chk("busy_low", busy, 0);

    repeat (10) step();
    s0 = n_start;
    bin_in = 14'd5;
    step();
    bin_in = 14'd6;
    step();
    bin_in = 14'd7;
    i = 0;
    while (!(n_start >= s0 + 2 && !busy && !ifc.conv_start)
           && i < 100) begin
      step();
      i++;
    end
    if (i >= 100) bound_fail("seq567");
    chk("second_bin", last_start_bin, 7);
    chk("gap_ge_uc",
        (last_start_cyc - prev_start_cyc) >= UC, 1);
    chk_disp("v7", 16'h0007, 4'b1110);

    repeat (10) step();
    s0 = n_start;
    bin_in = 14'd12000;
    wait_done(s0, 50, "done_sat");
    chk("sat_bin", last_start_bin, 9999);
    chk("sat_ovf", ovf, 1);
    chk_disp("v9999", 16'h9999, 4'b0000);

    repeat (10) step();
    s0 = n_start;
    bin_in = 14'd42;
    wait_done(s0, 50, "done_42");
    chk("ovf_clr", ovf, 0);
    chk_disp("v42", 16'h0042, 4'b1100);

    repeat (10) step();
    no_tick = 1'b1;
    s0 = n_start;
    bin_in = 14'd555;
    wait_start(s0, 20, "tmo_start");
    i = 0;
    while (!err && i < 40) begin
      step();
      i++;
    end
    chk("tmo_16", i, 16);
    chk_disp("tmo_keep", 16'h0042, 4'b1100);
    no_tick = 1'b0;
    s0 = n_start;
    wait_done(s0, 50, "retry");
    chk_disp("retry", 16'h0555, 4'b1000);
    chk("err_sticky", err, 1);

    repeat (10) step();
    hold_ready = 1'b1;
    step();
    s0 = n_start;
    force_req = 1'b1;
    step();
    force_req = 1'b0;
    repeat (20) step();
    chk("held_off", n_start - s0, 0);
    hold_ready = 1'b0;
    repeat (40) step();
    chk("one_conv", n_start - s0, 1);

    s0 = n_start;
    bin_in = 14'd777;
    wait_start(s0, 20, "rst_start");
    rst = 1'b1;
    bin_in = '0;
    step();
    rst = 1'b0;
    chk("mid_start", ifc.conv_start, 0);
    chk("mid_bin", ifc.conv_bin, 0);
    chk("mid_busy", busy, 0);
    chk("mid_err", err, 0);
    chk("mid_ovf", ovf, 0);
    chk_disp("mid", 16'h0000, 4'b1110);
    repeat (20) step();
    chk_disp("stale", 16'h0000, 4'b1110);
    chk("stale_nostart", n_start - s0, 1);

    repeat (3000) begin
      step();
      if ($urandom_range(7, 0) == 0)
        bin_in = ($urandom_range(3, 0) == 0) ?
                 W'($urandom_range(16383, 0)) :
                 W'($urandom_range(1200, 0));
      force_req = ($urandom_range(24, 0) == 0);
      if ($urandom_range(39, 0) == 0)
        hold_ready = !hold_ready;
    end
    force_req = 1'b0;
    hold_ready = 1'b0;
    repeat (50) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
